// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables, registered read data,
// zero-fill after reset and out-of-range address flagging.
module ram_sp_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;

  logic                mem_we_c;
  logic [IDX_W-1:0]    mem_idx_c;
  logic [DATA_W-1:0]   mem_wdata_c;
  logic [BE_W-1:0]     mem_be_c;
  logic                acc_c;
  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Full-width compare so large addresses never alias onto valid words.
  assign in_range_c = {1'b0, addr} < DEPTH_X;
  assign idx_c      = addr[IDX_W-1:0];
  assign acc_c      = req && !busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = cnt_q;
    mem_wdata_c = '0;
    mem_be_c    = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c = 1'b1;
        mem_be_c = '1;
        busy_d   = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
        if (acc_c) begin
          err_d = !in_range_c;
          if (!we) begin
            rvalid_d = 1'b1;
            rdata_d  = in_range_c ? mem[idx_c] : '0;
          end else if (in_range_c) begin
            mem_we_c    = 1'b1;
            mem_idx_c   = idx_c;
            mem_wdata_c = wdata;
            mem_be_c    = be;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Storage array has no reset; the fill sequence provides known contents.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (mem_be_c[i]) begin
          mem[mem_idx_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: doc/ram_sp_be.md
# ram_sp_be

Parametrised single-port synchronous RAM with per-byte write enables, registered read data, an automatic zero-fill sequence after reset, and out-of-range address detection. Next-generation data/instruction memory for the RISC-V core: replaces the fixed 32×32 combinational-read array with a deterministic, word-addressed, one-cycle-latency memory whose contents are known after reset.

## Interface

Parameters:
- DATA_W, default 32, word width in bits; must be a multiple of 8.
- DEPTH, default 64, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- ADDR_W, default 32, address width; the address is a word index, not a byte address.
- BE_W, default DATA_W/8, byte-enable width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  access request, sampled on the rising edge.
- we  input  1  1 = write, 0 = read; qualified by req.
- be  input  BE_W  byte enables for writes; bit i selects bits [8i+7:8i]; ignored on reads.
- addr  input  ADDR_W  word index.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  one-cycle pulse; rdata is valid.
- err  output  1  one-cycle pulse; the accepted request had addr ≥ DEPTH.
- busy  output  1  zero-fill in progress; requests are not accepted.

## Operation

- The FSM has two states: CLEAR and READY.
- While rst is high: state = CLEAR, fill counter = 0, busy = 1, rdata = 0, rvalid = 0, err = 0. Array contents are not reset directly.
- CLEAR: each rising edge writes mem[cnt] = 0 and increments cnt. The edge that writes mem[DEPTH-1] moves the FSM to READY and clears busy. busy is a registered output.
- READY: a request is accepted on any rising edge with req=1 and busy=0.
  - Read, in range: rdata ← mem[addr], rvalid = 1 on the next cycle.
  - Write, in range: for each i with be[i]=1, mem[addr] byte i ← wdata byte i. Bytes with be[i]=0 keep their value. No rvalid.
  - be = 0 on a write is legal; it changes nothing.
  - Out of range (addr ≥ DEPTH), read or write: the array is untouched, err = 1 for one cycle. A read also sets rdata = 0 and rvalid = 1. A write does not pulse rvalid.
- Requests arriving while busy=1 are dropped silently: no rvalid, no err, no array change.
- rdata holds its last value until the next accepted read. rvalid and err are 0 in every cycle without a corresponding accepted request.
- Reset asserted mid-CLEAR or mid-access: all outputs return to their reset values immediately, and CLEAR restarts from word 0 after release. A write in flight on the edge coincident with reset assertion is not guaranteed.

## Timing

- busy is high from reset assertion through exactly DEPTH rising edges after reset release. The first request that can be accepted is sampled on edge DEPTH+1.
- Read latency is 1 cycle: a request accepted at edge N gives rdata/rvalid valid after edge N, for one cycle.
- Full throughput: one accepted request per cycle, with back-to-back reads and writes in any mix.
- Read-after-write to the same address on consecutive edges returns the newly written data.
- A read and a write cannot occur on the same edge (single port). The read-first vs write-first question therefore does not apply within one edge.
- err pulses on the same cycle as the rvalid it would accompany.
- Width rules: the address compares against DEPTH at full ADDR_W width. No truncation or wrap-around, so addr = DEPTH and addr = 2^ADDR_W−1 both flag err.

## Test plan

- Reset fill (DEPTH=64): release rst, hold req=1 read addr 5 continuously. busy stays 1 for 64 edges with no rvalid. The first rvalid follows edge 65 with rdata = 0. Read all 64 words: all 0.
- Full write/readback: write mem[i] = 0xA5000000 + i for i = 0..63 with be = 4'hF, then read back-to-back. rvalid is high on 64 consecutive cycles and rdata matches each word in order.
- Byte enables: write 0x11223344 (be=F) to addr 7, write 0xAABBCCDD (be=4'b0101) to addr 7, write 0xFFFFFFFF (be=0) to addr 7. A read of addr 7 returns 0x11BB33DD.
- Read-after-write: write 0xDEADBEEF to addr 3 at edge N, read addr 3 at edge N+1. rdata = 0xDEADBEEF after edge N+1.
- Out of range: read addr 64 → rvalid=1, err=1, rdata=0. Write 0x12345678 to addr 0xFFFFFFFF → err=1, rvalid=0. A read of addr 63 is unchanged, err=0.
- Reset mid-operation: assert rst at fill cycle 30, and again during a read burst. rvalid, err and rdata go to 0 immediately and busy goes to 1. After release, busy lasts exactly 64 edges again and a prior write to addr 10 reads back 0.
